// File: rtl/conv_pkg.sv
// Shared state enum, width helpers and output formatting for conv2d_engine.
// Build option CONV_SAT_EN: clamp results to the pixel range instead of wrapping.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One spare bit beyond the worst-case sum of K*K signed products.
  function automatic int acc_width(input int data_w, input int coef_w, input int k);
    return data_w + coef_w + clog2(k * k) + 1;
  endfunction

  function automatic logic [63:0] fmt_pix(input logic signed [63:0] v, input int data_w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
`ifdef CONV_SAT_EN
    if (v < 0) return '0;
    if (v > max_v) return max_v;
    return v;
`else
    return v & max_v;
`endif
  endfunction

endpackage

// File: rtl/conv2d_engine_mac.sv
// Signed multiply-accumulate for one kernel tap per cycle; clear wins over enable.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = acc_width(8, 8, 3)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DATA_W-1:0]        pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc_sum
);
  localparam int PW = DATA_W + COEF_W + 1;

  logic signed [PW-1:0]    pix_x;
  logic signed [PW-1:0]    coef_x;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  assign pix_x   = signed'({{COEF_W{1'b0}}, 1'b0, pix});
  assign coef_x  = PW'(coef);
  assign prod    = pix_x * coef_x;
  assign acc_sum = acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) acc_d = '0;
    else if (en) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clock) begin
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/conv2d_engine.sv
// K x K valid-region convolution over an external sync-read image; K*K+2 cycles per pixel.
// Build option CONV_SAT_EN selects saturating output (see conv_pkg::fmt_pix).
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [ADDR_W-1:0]        dst_base,
  input  logic [K*K*COEF_W-1:0]    coeffs,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done
);
  localparam int KK    = K * K;
  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, K);
  localparam int TW    = clog2(KK) + 1;
  localparam int KW    = clog2(K) + 1;
  localparam int CW    = clog2(IMG_W) + 1;
  localparam int RW    = clog2(IMG_H) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(KK - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OH - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0]     src_q, src_d, dst_q, dst_d;
  logic [KK*COEF_W-1:0]  coef_q, coef_d;
  logic [TW-1:0]         t_q, t_d, prev_t_q, prev_t_d;
  logic [KW-1:0]         kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0]         c_q, c_d;
  logic [RW-1:0]         r_q, r_d;
  logic                  mac_en_q, mac_en_d, mac_clr;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic signed [COEF_W-1:0] tap_coef;
  logic signed [ACC_W-1:0]  acc_sum, acc_shift;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] row,
                                                 input logic [ADDR_W-1:0] col,
                                                 input int                w);
    return base + row * ADDR_W'(w) + col;
  endfunction

  // Read data lags its strobe by one cycle, so the MAC uses the previous tap's coefficient.
  assign tap_coef  = coef_q[int'(prev_t_q) * COEF_W +: COEF_W];
  assign acc_shift = acc_sum >>> SHIFT;

  conv_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clock   (clock),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en_q),
    .pix     (rd_data),
    .coef    (tap_coef),
    .acc_sum (acc_sum)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    coef_d    = coef_q;
    t_d       = t_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    c_d       = c_q;
    r_d       = r_q;
    prev_t_d  = t_q;
    mac_en_d  = rd_en_q;
    mac_clr   = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FETCH;
          src_d     = src_base;
          dst_d     = dst_base;
          coef_d    = coeffs;
          t_d       = '0;
          kx_d      = '0;
          ky_d      = '0;
          c_d       = '0;
          r_d       = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = src_base;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          mac_clr   = 1'b1;
        end
      end
      FETCH: begin
        if (t_q == T_LAST) begin
          state_d = DRAIN;
        end else begin
          t_d = t_q + TW'(1);
          if (kx_q == K_LAST) begin
            kx_d = '0;
            ky_d = ky_q + KW'(1);
          end else begin
            kx_d = kx_q + KW'(1);
          end
          rd_en_d   = 1'b1;
          rd_addr_d = pix_addr(src_q, ADDR_W'(r_q) + ADDR_W'(ky_d),
                               ADDR_W'(c_q) + ADDR_W'(kx_d), IMG_W);
        end
      end
      DRAIN: begin
        state_d   = WRITE;
        wr_en_d   = 1'b1;
        wr_addr_d = pix_addr(dst_q, ADDR_W'(r_q), ADDR_W'(c_q), OW);
        wr_data_d = DATA_W'(fmt_pix(64'(acc_shift), DATA_W));
      end
      WRITE: begin
        t_d  = '0;
        kx_d = '0;
        ky_d = '0;
        if (r_q == R_LAST && c_q == C_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (c_q == C_LAST) begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
          state_d   = FETCH;
          rd_en_d   = 1'b1;
          rd_addr_d = pix_addr(src_q, ADDR_W'(r_d), ADDR_W'(c_d), IMG_W);
          mac_clr   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      coef_q    <= '0;
      t_q       <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      c_q       <= '0;
      r_q       <= '0;
      prev_t_q  <= '0;
      mac_en_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      coef_q    <= coef_d;
      t_q       <= t_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      c_q       <= c_d;
      r_q       <= r_d;
      prev_t_q  <= prev_t_d;
      mac_en_q  <= mac_en_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine (default 8x8 image, 3x3 kernel).
module tb_conv2d_engine;
  typedef int kern_t [9];
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [15:0] dst_base = '0;
  logic [71:0] coeffs = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  conv2d_engine #(
    .DATA_W(8), .COEF_W(8), .IMG_W(8), .IMG_H(8), .K(3), .SHIFT(0), .ADDR_W(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .coeffs(coeffs),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  wr_count = 0;
  int  last_wr_rel = 0;
  bit  seen_zero = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clock) begin : monitor
    wr_t e;
    if (wr_en === 1'b1) begin
      wr_count++;
      last_wr_rel = cyc - start_cyc + 1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%h data=%0d with empty scoreboard", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          fails++;
          $display("FAIL write_check: got addr=%h data=%0d, expected addr=%h data=%0d",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (rd_en === 1'b1 && rd_addr == 16'h0000) seen_zero = 1'b1;
    if (busy === 1'b1 && done === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL busy_done_overlap: busy=1 done=1 at cycle %0d", cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [71:0] pack(input kern_t k);
    logic [71:0] v;
    v = '0;
    for (int t = 0; t < 9; t++) v[t*8 +: 8] = 8'(k[t]);
    return v;
  endfunction

  // Centre tap of 1 over a ramp where pixel value equals its address.
  task automatic push_identity(input logic [15:0] d, input int npix);
    wr_t e;
    for (int p = 0; p < npix; p++) begin
      e.addr = d + 16'((p / 6) * 6 + (p % 6));
      e.data = 8'(((p / 6) + 1) * 8 + (p % 6) + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(input logic [15:0] d, input logic [7:0] v);
    wr_t e;
    for (int p = 0; p < 36; p++) begin
      e.addr = d + 16'(p);
      e.data = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ref(input logic [15:0] s, input logic [15:0] d, input kern_t k);
    wr_t e;
    int acc;
    logic [15:0] a;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            a = s + 16'((r + ky) * 8 + c + kx);
            acc += int'(mem[a]) * k[ky*3 + kx];
          end
        end
`ifdef CONV_SAT_EN
        if (acc < 0) acc = 0;
        else if (acc > 255) acc = 255;
`endif
        e.addr = d + 16'(r * 6 + c);
        e.data = 8'(acc);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_run(input logic [15:0] s, input logic [15:0] d, input logic [71:0] cv);
    @(negedge clock);
    src_base = s;
    dst_base = d;
    coeffs   = cv;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    wr_count  = 0;
    src_base  = 16'hBEEF;
    dst_base  = 16'hCAFE;
    coeffs    = '1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_done_cycle"}, cyc - start_cyc + 1, 397);
    chk({name, "_last_write_cycle"}, last_wr_rel, 396);
    chk({name, "_write_count"}, wr_count, 36);
    chk({name, "_scoreboard_left"}, exp_q.size(), 0);
    chk({name, "_busy_low"}, {31'b0, busy}, 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    kern_t k_id, k_ones, k_neg, k_wrap;
    int viol;
    logic [15:0] a;
    k_id   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    k_ones = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    k_neg  = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
    k_wrap = '{3, -1, 2, -5, 7, 1, -2, 4, -3};
    for (int i = 0; i < 64; i++) begin
      mem[i]           = 8'(i);
      mem[16'h1000 + i] = 8'd200;
      mem[16'h3000 + i] = 8'd50;
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_rd_en", {31'b0, rd_en}, 0);
    chk("reset_rd_addr", {16'b0, rd_addr}, 0);
    chk("reset_wr_en", {31'b0, wr_en}, 0);
    chk("reset_wr_addr", {16'b0, wr_addr}, 0);
    chk("reset_wr_data", {24'b0, wr_data}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    reset = 1'b0;

    push_identity(16'h8000, 36);
    start_run(16'h0000, 16'h8000, pack(k_id));
    wait_done("identity");

`ifdef CONV_SAT_EN
    push_const(16'h8100, 8'd255);
`else
    push_const(16'h8100, 8'd8);
`endif
    start_run(16'h1000, 16'h8100, pack(k_ones));
    wait_done("ones_200");

`ifdef CONV_SAT_EN
    push_const(16'h8200, 8'd0);
`else
    push_const(16'h8200, 8'd206);
`endif
    start_run(16'h3000, 16'h8200, pack(k_neg));
    wait_done("neg_centre");

    // Second start mid-run must be ignored.
    push_identity(16'h8000, 36);
    start_run(16'h0000, 16'h8000, pack(k_id));
    while (cyc - start_cyc + 1 < 100) @(negedge clock);
    src_base = 16'h1000;
    dst_base = 16'h9000;
    coeffs   = pack(k_ones);
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("restart_ignored");

    // Reset in cycle 150: pixels 0..12 are already written by then.
    push_identity(16'h8000, 13);
    start_run(16'h0000, 16'h8000, pack(k_id));
    while (cyc - start_cyc + 1 < 150) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    viol = 0;
    repeat (60) begin
      @(negedge clock);
      if (rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("midreset_activity", viol, 0);
    chk("midreset_write_count", wr_count, 13);
    chk("midreset_last_write_cycle", last_wr_rel, 143);
    chk("midreset_scoreboard_left", exp_q.size(), 0);
    exp_q.delete();

    push_identity(16'h8000, 36);
    start_run(16'h0000, 16'h8000, pack(k_id));
    wait_done("after_reset");

    for (int i = 0; i < 64; i++) begin
      a = 16'hFFF0 + 16'(i);
      mem[a] = 8'((i * 37 + 11) & 255);
    end
    seen_zero = 1'b0;
    push_ref(16'hFFF0, 16'h8300, k_wrap);
    start_run(16'hFFF0, 16'h8300, pack(k_wrap));
    wait_done("addr_wrap");
    chk("addr_wrap_read_0000", {31'b0, seen_zero}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv2d_engine.md
# conv2d_engine

- Parametrised 2-D convolution engine; successor to the fixed 8-bit `Convolution` block.
- Slides a K×K signed kernel over an IMG_W×IMG_H unsigned image held in an external synchronous-read memory.
- Writes the valid (unpadded) output image, (IMG_W−K+1)×(IMG_H−K+1) pixels, to an external write port.
- Sits between the image buffer and the result buffer; a host controls it with a start/done handshake.

## Interface
- DATA_W, 8: pixel width (unsigned), in and out.
- COEF_W, 8: coefficient width (signed, two's complement).
- IMG_W, 8: image width in pixels.
- IMG_H, 8: image height in pixels.
- K, 3: kernel side, ≥1, ≤ min(IMG_W, IMG_H).
- SHIFT, 0: arithmetic right shift applied to the accumulator before output.
- ADDR_W, 16: memory address width.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- src_base  in  ADDR_W  input image base address.
- dst_base  in  ADDR_W  output image base address.
- coeffs  in  K*K*COEF_W  kernel, row-major; tap 0 sits at the LSBs.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  result write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  result pixel.
- busy  out  1  high from the cycle after start is accepted until the final write.
- done  out  1  level; held until the next accepted start or reset.

## Operation
- Output dimensions: OW = IMG_W−K+1, OH = IMG_H−K+1.
- Start acceptance: on an accepted start, the engine registers src_base, dst_base and coeffs; later input changes have no effect. Accepting start clears done.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
  - IDLE/DONE → FETCH on start.
  - FETCH lasts K*K cycles; each cycle issues tap t, with rd_addr = src + (r+ky)*IMG_W + (c+kx).
  - FETCH → DRAIN after the last tap.
  - DRAIN → WRITE.
  - WRITE → FETCH for the next pixel, or → DONE after pixel (OH−1, OW−1).
- Scan order is row-major. Each write has wr_addr = dst + r*OW + c.
- Address arithmetic wraps modulo 2^ADDR_W.
- MAC: acc += rd_data (zero-extended) × coeff[t−1], performed on the cycle after tap t−1 is issued. The last tap is accumulated in DRAIN.
- acc is cleared at entry to each FETCH.
- ACC_W = DATA_W + COEF_W + clog2(K*K) + 1, signed; overflow is impossible at this width.
- Result = acc >>> SHIFT, then formatted per Configuration.
- Start while busy is ignored entirely.
- done and busy are never high together.

## Timing
- Reset values: rd_en, rd_addr, wr_en, wr_addr, wr_data, busy and done are all 0. State is IDLE; acc is 0.
- Per-pixel cost: K*K + 2 cycles.
- Total run length: with start accepted in cycle 0, the last WRITE occurs in cycle OW*OH*(K*K+2). done rises in the next cycle.
- Defaults: 36 × 11 = 396, so done = 1 in cycle 397.
- wr_en is a single-cycle pulse per pixel; wr_addr and wr_data are valid in the same cycle.
- rd_en is high in every FETCH cycle and low otherwise.
- Reset mid-run: the engine returns to IDLE in the next cycle. There are no further rd_en or wr_en pulses, and done stays 0.
- Start in the same cycle as reset: reset wins.

## Configuration
- CONV_SAT_EN defined: the result clamps to [0, 2^DATA_W − 1]. Negative values become 0; oversize values become the maximum.
- CONV_SAT_EN undefined: the result is the low DATA_W bits of the shifted accumulator (wrap-around).

## Structure
- Package `conv_pkg` holds:
  - the FSM state enum;
  - a `clog2` function;
  - the ACC_W derivation;
  - the saturate/wrap function, with its body selected by CONV_SAT_EN.
- Sub-module `conv_mac` holds the signed multiplier and accumulator, with clear and enable inputs. The engine owns the FSM, counters (t, kx, ky, c, r) and address generation.

## Test plan
- Identity kernel (centre 1, others 0), 8×8 ramp image pix = addr, SHIFT 0 → out[r][c] = img[r+1][c+1]. Expect 36 writes to dst..dst+35 and done in cycle 397.
- All-ones kernel, image all 200 → acc 1800. With CONV_SAT_EN, out is 255; without it, out is 8.
- Centre coefficient −1, image all 50 → acc −50. With CONV_SAT_EN, out is 0; without it, out is 206.
- Start pulsed again at cycle 100 with different coeffs → ignored; outputs are identical to the first test.
- Reset asserted at cycle 150 → no wr_en after cycle 151 and done stays 0. A fresh start then completes normally.
- src_base = 0xFFF0 → rd_addr wraps through 0x0000. Results match a reference model using a modulo-2^16 memory.
